// File: rtl/midi_uart_rx.sv
// rtl/midi_uart_rx.sv - MIDI 8N1 serial receiver with framing-error detection
// Optional MIDI_RX_MAJORITY_VOTE_EN: 3-sample majority vote at each sample point.
module midi_uart_rx #(
  parameter int CLKS_PER_BIT = 384
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       frame_err,
  output logic       busy
);

  localparam int HALF = CLKS_PER_BIT >> 1;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          sample;
  logic          sample_pt;

`ifdef MIDI_RX_MAJORITY_VOTE_EN
  logic [1:0] hist;

  // Idle-high history so the first start bit after reset is not biased.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hist <= 2'b11;
    else     hist <= {hist[0], rx_in};
  end

  assign sample = (rx_in & hist[0]) | (rx_in & hist[1]) | (hist[0] & hist[1]);
`else
  assign sample = rx_in;
`endif

  assign sample_pt = ((state == START) && (cnt == HALF_LAST)) ||
                     (((state == DATA) || (state == STOP)) && (cnt == BIT_LAST));

  assign busy = (state != IDLE);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (!rx_in) state_n = START;
      START:   if (sample_pt) state_n = sample ? IDLE : DATA;
      DATA:    if (sample_pt && (bit_idx == 3'd7)) state_n = STOP;
      STOP:    if (sample_pt) state_n = sample ? IDLE : BREAK;
      BREAK:   if (rx_in) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Counter is held at zero outside the timed states so it never wraps mid-bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if ((state == IDLE) || (state == BREAK) || sample_pt) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_idx   <= 3'd0;
      shreg     <= 8'h00;
      data_out  <= 8'h00;
      valid_out <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      frame_err <= 1'b0;
      if (sample_pt) begin
        case (state)
          START: bit_idx <= 3'd0;
          DATA: begin
            shreg   <= {sample, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end
          STOP: begin
            if (sample) begin
              data_out  <= shreg;
              valid_out <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_midi_uart_rx.sv
// tb/tb_midi_uart_rx.sv - self-checking bench for midi_uart_rx (CLKS_PER_BIT = 16)
module tb_midi_uart_rx;

  localparam int CPB     = 16;
  localparam int HALF    = CPB / 2;
  localparam int STOP_AT = HALF + 9 * CPB;

`ifdef MIDI_RX_MAJORITY_VOTE_EN
  localparam bit         MAJ  = 1'b1;
  localparam logic [7:0] EXP6 = 8'hA5;
`else
  localparam bit         MAJ  = 1'b0;
  localparam logic [7:0] EXP6 = 8'hA1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       frame_err;
  logic       busy;

  midi_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         c;
    logic [7:0] d;
  } ev_t;

  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  ev_t        vq[$];
  int         eq[$];
  int         blo[$];
  int         bhi[$];
  logic [7:0] exp_data = 8'h00;
  int         vlog_c[$];
  logic [7:0] vlog_d[$];
  int         busy_cnt = 0;
  int         err_cnt = 0;
  logic       ev_v, ev_e, eb;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Outputs are observed at the falling edge following each rising edge numbered cyc.
  always @(negedge clk) begin
    if (rst) begin
      exp_data = 8'h00;
      chk("rst_data", {24'd0, data_out}, 32'h00);
      chk("rst_valid", {31'd0, valid_out}, 32'd0);
      chk("rst_ferr", {31'd0, frame_err}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
    end else begin
      ev_v = 1'b0;
      ev_e = 1'b0;
      eb   = 1'b0;
      while (vq.size() > 0 && vq[0].c <= cyc) begin
        if (vq[0].c == cyc) begin
          ev_v     = 1'b1;
          exp_data = vq[0].d;
        end
        void'(vq.pop_front());
      end
      while (eq.size() > 0 && eq[0] <= cyc) begin
        if (eq[0] == cyc) ev_e = 1'b1;
        void'(eq.pop_front());
      end
      for (int i = 0; i < blo.size(); i++)
        if (cyc >= blo[i] && cyc <= bhi[i]) eb = 1'b1;
      chk("valid_out", {31'd0, valid_out}, {31'd0, ev_v});
      chk("frame_err", {31'd0, frame_err}, {31'd0, ev_e});
      chk("data_out", {24'd0, data_out}, {24'd0, exp_data});
      chk("busy", {31'd0, busy}, {31'd0, eb});
      if (valid_out) begin
        vlog_c.push_back(cyc);
        vlog_d.push_back(data_out);
      end
      if (busy) busy_cnt++;
      if (frame_err) err_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one 8N1 frame and records what the receiver must report for it.
  task automatic send_frame(input logic [7:0] b, input bit stop, input int extra_low,
                            input int spike_bit, output int t0);
    logic [9:0] bits;
    logic [7:0] got;
    bits = {stop, b, 1'b0};
    t0   = cyc + 1;
    got  = (spike_bit >= 0 && !MAJ) ? (b ^ (8'd1 << spike_bit)) : b;
    if (stop) begin
      vq.push_back('{t0 + STOP_AT, got});
      blo.push_back(t0);
      bhi.push_back(t0 + STOP_AT - 1);
    end else begin
      eq.push_back(t0 + STOP_AT);
      blo.push_back(t0);
      bhi.push_back(t0 + 10 * CPB - 1 + extra_low);
    end
    for (int k = 0; k < 10; k++) begin
      rx_in = bits[k];
      if (spike_bit >= 0 && k == spike_bit + 1) begin
        tick(HALF);
        rx_in = ~bits[k];
        tick(1);
        rx_in = bits[k];
        tick(CPB - HALF - 1);
      end else begin
        tick(CPB);
      end
    end
    if (!stop) begin
      tick(extra_low);
      rx_in = 1'b1;
    end
  endtask

  int t0, t1, nv, ne, nb;

  initial begin
    rst   = 1'b0;
    rx_in = 1'b1;
    #1 rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(10);

    // 1: 0x90, good stop
    nv = vlog_c.size();
    ne = err_cnt;
    send_frame(8'h90, 1'b1, 0, -1, t0);
    chk("t1_count", vlog_c.size() - nv, 1);
    chk("t1_cycle", vlog_c[vlog_c.size()-1], t0 + 152);
    chk("t1_data", {24'd0, vlog_d[vlog_d.size()-1]}, 32'h90);
    chk("t1_noerr", err_cnt - ne, 0);
    tick(20);

    // 2: 3-cycle glitch
    nv = vlog_c.size();
    nb = busy_cnt;
    rx_in = 1'b0;
    blo.push_back(cyc + 1);
    bhi.push_back(cyc + HALF);
    tick(3);
    rx_in = 1'b1;
    tick(30);
    chk("t2_novalid", vlog_c.size() - nv, 0);
    chk("t2_busy_le9", (busy_cnt - nb) <= 9, 1);
    chk("t2_busy_seen", (busy_cnt - nb) > 0, 1);
    chk("t2_idle", {31'd0, busy}, 0);

    // 3: 0x55 with bad stop, line held low, then 0x3C
    ne = err_cnt;
    send_frame(8'h55, 1'b0, 40, -1, t0);
    tick(20);
    chk("t3_one_err", err_cnt - ne, 1);
    chk("t3_keep", {24'd0, data_out}, 32'h90);
    send_frame(8'h3C, 1'b1, 0, -1, t0);
    tick(20);
    chk("t3_next", {24'd0, vlog_d[vlog_d.size()-1]}, 32'h3C);

    // 4: back-to-back 0xF8, 0x00
    nv = vlog_c.size();
    send_frame(8'hF8, 1'b1, 0, -1, t0);
    send_frame(8'h00, 1'b1, 0, -1, t1);
    tick(20);
    chk("t4_count", vlog_c.size() - nv, 2);
    chk("t4_gap", vlog_c[nv+1] - vlog_c[nv], 160);
    chk("t4_d0", {24'd0, vlog_d[nv]}, 32'hF8);
    chk("t4_d1", {24'd0, vlog_d[nv+1]}, 32'h00);

    // 5: reset in data bit 4 of 0xC3
    nv = vlog_c.size();
    rx_in = 1'b0;
    t0 = cyc + 1;
    blo.push_back(t0);
    bhi.push_back(t0 + 5 * CPB + HALF - 2);
    tick(CPB);
    for (int k = 0; k < 4; k++) begin
      rx_in = k < 2;
      tick(CPB);
    end
    rx_in = 1'b0;
    tick(HALF - 1);
    rst   = 1'b1;
    rx_in = 1'b1;
    #1;
    chk("t5_imm_data", {24'd0, data_out}, 32'h00);
    chk("t5_imm_busy", {31'd0, busy}, 0);
    chk("t5_imm_valid", {31'd0, valid_out}, 0);
    chk("t5_imm_ferr", {31'd0, frame_err}, 0);
    tick(2);
    rst = 1'b0;
    tick(20);
    chk("t5_nopulse", vlog_c.size() - nv, 0);
    send_frame(8'hC3, 1'b1, 0, -1, t0);
    tick(20);
    chk("t5_data", {24'd0, data_out}, 32'hC3);

    // 6: 0xA5 with a spike on bit 2's sample point
    send_frame(8'hA5, 1'b1, 0, 2, t0);
    tick(20);
    chk("t6_data", {24'd0, data_out}, {24'd0, EXP6});

    chk("pending_valid", vq.size(), 0);
    chk("pending_err", eq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
